sa_interval_collector: RTL and testbench

Result-side stage downstream of the accelerator control pipeline. Captures the suffix-array intervals `[k,l]` emitted when a search path completes (`i < 0` hit in the execute/write-back stage) and buffers them in a FIFO. Drops empty and consecutively repeated intervals. Streams the buffered intervals to the host side over a valid/ready port, and signals `done_o` once the accelerator has finished and the FIFO has drained.

---
 rtl/sa_interval_collector.sv | 127 ++++++++++++
 tb/tb_sa_interval_collector.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_interval_collector.sv
// Interval collector: filters completed suffix-array intervals into a FWFT FIFO
// and streams them to the host, signalling done once the run has drained.
module sa_interval_collector #(
   parameter int DEPTH = 16,
   parameter int KW    = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start_i,
   input  logic          hit_i,
   input  logic [KW-1:0] hit_k_i,
   input  logic [KW-1:0] hit_l_i,
   input  logic          finish_i,
   output logic          out_valid_o,
   input  logic          out_ready_i,
   output logic [KW-1:0] out_k_o,
   output logic [KW-1:0] out_l_o,
   output logic [7:0]    count_o,
   output logic          overflow_o,
   output logic          full_o,
   output logic          empty_o,
   output logic          busy_o,
   output logic          done_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       occ_q, occ_d;
   logic [7:0]        count_q, count_d;
   logic              ovf_q, ovf_d;
   logic              last_vld_q, last_vld_d;
   logic [2*KW-1:0]   last_q, last_d;
   logic [2*KW-1:0]   mem_q [DEPTH];

   logic              fifo_full, fifo_empty, active, out_valid;
   logic              hit_ok, push, pop;
   logic [2*KW-1:0]   hit_kl;

   always_comb begin
      hit_kl     = {hit_k_i, hit_l_i};
      fifo_full  = (occ_q == OCC_FULL);
      fifo_empty = (occ_q == '0);
      active     = (state_q == S_COLLECT) || (state_q == S_DRAIN);
      out_valid  = active && !fifo_empty;
      // start_i discards any pop or hit presented in the same cycle
      pop        = out_valid && out_ready_i && !start_i;
      hit_ok     = (state_q == S_COLLECT) && hit_i && !start_i &&
                   (hit_k_i <= hit_l_i) && !(last_vld_q && (last_q == hit_kl));
      push       = hit_ok && (!fifo_full || pop);
   end

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      occ_d      = occ_q;
      count_d    = count_q;
      ovf_d      = ovf_q;
      last_vld_d = last_vld_q;
      last_d     = last_q;
      if (start_i) begin
         state_d    = S_COLLECT;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         occ_d      = '0;
         count_d    = '0;
         ovf_d      = 1'b0;
         last_vld_d = 1'b0;
      end else begin
         if (push) begin
            wr_ptr_d   = wr_ptr_q + AW'(1);
            last_d     = hit_kl;
            last_vld_d = 1'b1;
            if (count_q != 8'hFF) count_d = count_q + 8'd1;
         end
         if (hit_ok && !push) ovf_d = 1'b1;
         if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
         occ_d = occ_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
         case (state_q)
            S_COLLECT: if (finish_i) state_d = S_DRAIN;
            S_DRAIN:   if (fifo_empty) state_d = S_DONE;
            default:   state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         last_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         last_vld_q <= last_vld_d;
      end
   end

   // Storage carries no reset; validity is tracked by last_vld_q and occupancy
   always_ff @(posedge clk) begin
      last_q <= last_d;
      if (push) mem_q[wr_ptr_q] <= hit_kl;
   end

   assign out_valid_o = out_valid;
   assign out_k_o     = out_valid ? mem_q[rd_ptr_q][2*KW-1:KW] : '0;
   assign out_l_o     = out_valid ? mem_q[rd_ptr_q][KW-1:0]    : '0;
   assign count_o     = count_q;
   assign overflow_o  = ovf_q;
   assign full_o      = fifo_full;
   assign empty_o     = fifo_empty;
   assign busy_o      = active;
   assign done_o      = (state_q == S_DONE);
endmodule

// File: tb/tb_sa_interval_collector.sv
// Bench for sa_interval_collector: directed test-plan scenarios plus random
// traffic, all checked every cycle against a queue-based reference model.
module tb_sa_interval_collector;
   localparam int DEPTH = 16;
   localparam int KW    = 8;
   typedef logic [2*KW-1:0] ent_t;

   logic          clk = 1'b0;
   logic          rst_n, start_i, hit_i, finish_i, out_ready_i;
   logic [KW-1:0] hit_k_i, hit_l_i;
   logic          out_valid_o, overflow_o, full_o, empty_o, busy_o, done_o;
   logic [KW-1:0] out_k_o, out_l_o;
   logic [7:0]    count_o;

   always #5 clk = ~clk;

   sa_interval_collector #(.DEPTH(DEPTH), .KW(KW)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .hit_i(hit_i),
      .hit_k_i(hit_k_i), .hit_l_i(hit_l_i), .finish_i(finish_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_k_o(out_k_o), .out_l_o(out_l_o), .count_o(count_o),
      .overflow_o(overflow_o), .full_o(full_o), .empty_o(empty_o),
      .busy_o(busy_o), .done_o(done_o)
   );

   int   n_chk = 0;
   int   n_fail = 0;
   // reference model: 0 idle, 1 collect, 2 drain, 3 done
   int   m_st = 0;
   int   m_cnt = 0;
   bit   m_ovf = 0;
   bit   m_lv = 0;
   ent_t m_last = '0;
   ent_t m_q[$];
   ent_t dut_out[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step();
      bit   mv, mpop, mhv;
      int   sz;
      ent_t kl;
      sz = m_q.size();
      kl = {hit_k_i, hit_l_i};
      mv = (m_st == 1 || m_st == 2) && sz > 0;
      if (!rst_n || start_i) begin
         m_q.delete();
         m_st = rst_n ? 1 : 0;
         m_cnt = 0; m_ovf = 0; m_lv = 0;
      end else begin
         mpop = mv && out_ready_i;
         mhv  = (m_st == 1) && hit_i && (hit_k_i <= hit_l_i) && !(m_lv && m_last == kl);
         if (mpop) void'(m_q.pop_front());
         if (mhv) begin
            if (sz < DEPTH || mpop) begin
               m_q.push_back(kl);
               m_last = kl; m_lv = 1;
               if (m_cnt < 255) m_cnt++;
            end else m_ovf = 1;
         end
         if (m_st == 1 && finish_i) m_st = 2;
         else if (m_st == 2 && sz == 0) m_st = 3;
      end
   endtask

   task automatic compare_all();
      bit mv;
      mv = (m_st == 1 || m_st == 2) && m_q.size() > 0;
      chk("out_valid", out_valid_o, mv);
      chk("out_k", out_k_o, mv ? m_q[0][2*KW-1:KW] : 0);
      chk("out_l", out_l_o, mv ? m_q[0][KW-1:0] : 0);
      chk("count", count_o, m_cnt);
      chk("overflow", overflow_o, m_ovf);
      chk("full", full_o, m_q.size() == DEPTH);
      chk("empty", empty_o, m_q.size() == 0);
      chk("busy", busy_o, m_st == 1 || m_st == 2);
      chk("done", done_o, m_st == 3);
   endtask

   task automatic step();
      if (rst_n && !start_i && out_valid_o && out_ready_i)
         dut_out.push_back({out_k_o, out_l_o});
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic hit(input int k, input int l);
      hit_i = 1'b1; hit_k_i = KW'(k); hit_l_i = KW'(l);
      step();
      hit_i = 1'b0;
   endtask

   task automatic do_start();
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      dut_out.delete();
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!done_o && n < budget) begin
         step();
         n++;
      end
      chk("done_reached", done_o, 1);
   endtask

   task automatic chk_out(input string tag, input int idx, input int k, input int l);
      if (idx < dut_out.size()) chk(tag, dut_out[idx], {KW'(k), KW'(l)});
      else chk({tag, "_missing"}, 0, 1);
   endtask

   initial begin
      rst_n = 1'b0; start_i = 1'b0; hit_i = 1'b0; finish_i = 1'b0;
      out_ready_i = 1'b1; hit_k_i = '0; hit_l_i = '0;
      step(); step();
      chk("rst_empty", empty_o, 1);
      chk("rst_busy", busy_o, 0);
      rst_n = 1'b1;
      step();
      hit(1, 2);
      chk("idle_ignores_hit", count_o, 0);

      // basic run
      do_start();
      hit(3, 7);
      hit(10, 12);
      finish_i = 1'b1; step(); finish_i = 1'b0;
      wait_done(20);
      chk("basic_n", dut_out.size(), 2);
      chk_out("basic_0", 0, 3, 7);
      chk_out("basic_1", 1, 10, 12);
      chk("basic_count", count_o, 2);
      chk("basic_busy", busy_o, 0);

      // filter
      do_start();
      hit(5, 5); hit(5, 5); hit(9, 4); hit(6, 8); hit(5, 5);
      repeat (4) step();
      chk("filter_n", dut_out.size(), 3);
      chk_out("filter_0", 0, 5, 5);
      chk_out("filter_1", 1, 6, 8);
      chk_out("filter_2", 2, 5, 5);
      chk("filter_count", count_o, 3);

      // overflow and full
      do_start();
      out_ready_i = 1'b0;
      for (int i = 0; i < 18; i++) begin
         hit(i, i + 20);
         if (i == 15) chk("full_after_16", full_o, 1);
      end
      chk("ovf_set", overflow_o, 1);
      chk("ovf_count", count_o, 16);
      out_ready_i = 1'b1;
      for (int i = 18; i < 22; i++) hit(i, i + 20);
      out_ready_i = 1'b0;
      chk("full_hold", full_o, 1);
      chk("count_20", count_o, 20);
      out_ready_i = 1'b1;
      finish_i = 1'b1; step(); finish_i = 1'b0;
      wait_done(40);
      chk("ovf_drain_n", dut_out.size(), 20);
      chk_out("ovf_first", 0, 0, 20);

      // finish together with a hit
      do_start();
      finish_i = 1'b1; hit(1, 2); finish_i = 1'b0;
      wait_done(10);
      chk_out("fin_hit", 0, 1, 2);

      // finish with empty FIFO: done exactly two cycles later
      do_start();
      step();
      finish_i = 1'b1; step(); finish_i = 1'b0;
      chk("fin_empty_drain", busy_o, 1);
      chk("fin_empty_not_done", done_o, 0);
      step();
      chk("fin_empty_done", done_o, 1);
      finish_i = 1'b1; step(); finish_i = 1'b0;
      chk("finish_ignored_done", done_o, 1);

      // hits in drain are ignored
      do_start();
      out_ready_i = 1'b0;
      hit(1, 2);
      finish_i = 1'b1; step(); finish_i = 1'b0;
      hit(7, 9); hit(8, 9);
      chk("drain_count", count_o, 1);
      out_ready_i = 1'b1;
      wait_done(10);

      // restart mid-collect
      do_start();
      out_ready_i = 1'b0;
      for (int i = 0; i < 16; i++) hit(i, 50);
      hit(40, 50);
      hit(1, 3); hit(2, 3); hit(3, 5); hit(3, 6); hit(3, 7);
      do_start();
      chk("restart_empty", empty_o, 1);
      chk("restart_count", count_o, 0);
      chk("restart_ovf", overflow_o, 0);
      hit(3, 7);
      chk("restart_accept", count_o, 1);

      // reset during drain
      hit(4, 9);
      finish_i = 1'b1; step(); finish_i = 1'b0;
      chk("pre_rst_drain", busy_o, 1);
      rst_n = 1'b0; step(); rst_n = 1'b1;
      chk("rst_valid", out_valid_o, 0);
      chk("rst_k", out_k_o, 0);
      chk("rst_l", out_l_o, 0);
      chk("rst_count", count_o, 0);
      chk("rst_full", full_o, 0);
      chk("rst_empty2", empty_o, 1);
      chk("rst_done", done_o, 0);

      // pointer wrap with random back-pressure
      out_ready_i = 1'b1;
      do_start();
      begin
         int issued = 0;
         int guard = 0;
         while (issued < 40 && guard < 400) begin
            out_ready_i = $urandom_range(0, 1);
            if (m_q.size() < DEPTH && $urandom_range(0, 3) != 0) begin
               hit(issued, issued + 100);
               issued++;
            end else step();
            guard++;
         end
         chk("wrap_issued", issued, 40);
      end
      out_ready_i = 1'b1;
      finish_i = 1'b1; step(); finish_i = 1'b0;
      wait_done(40);
      chk("wrap_n", dut_out.size(), 40);
      for (int i = 0; i < 40; i++) chk_out("wrap_order", i, i, i + 100);
      chk("wrap_count", count_o, 40);

      // random traffic
      for (int c = 0; c < 600; c++) begin
         start_i     = ($urandom_range(0, 99) == 0);
         finish_i    = ($urandom_range(0, 29) == 0);
         hit_i       = $urandom_range(0, 1);
         hit_k_i     = KW'($urandom_range(0, 3));
         hit_l_i     = KW'($urandom_range(0, 3));
         out_ready_i = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
         step();
         rst_n = 1'b1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
